// File: rtl/dir_input_queue_if.sv
// Signal bundle between the push-button/tick front end and the direction queue.
// master drives buttons, tick and game state; slave (the queue) returns the applied direction.
interface dir_input_queue_if;
  logic [3:0] key_i;
  logic       tick_i;
  logic       playing_i;
  logic [3:0] direction_o;
  logic [2:0] count_o;
  logic       overflow_o;

  modport master (
    output key_i,
    output tick_i,
    output playing_i,
    input  direction_o,
    input  count_o,
    input  overflow_o
  );

  modport slave (
    input  key_i,
    input  tick_i,
    input  playing_i,
    output direction_o,
    output count_o,
    output overflow_o
  );
endinterface

// File: rtl/dir_input_queue.sv
// Debounced 4-key direction input with a small FIFO of pending turns popped on each snake tick.
// Optional macro DIR_QUEUE_REVERSE_BLOCK_EN: also discard presses opposite to the reference direction.
module dir_input_queue #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int QUEUE_DEPTH     = 2
) (
  input logic               clk_i,
  input logic               reset_i,
  dir_input_queue_if.slave  q_if
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [2:0]       DEPTH_C  = 3'(QUEUE_DEPTH);
  localparam logic [3:0]       DIR_RIGHT = 4'b1000;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] prev_ptr(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

`ifdef DIR_QUEUE_REVERSE_BLOCK_EN
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction
`endif

  logic [3:0]       key_sync_p0;
  logic [3:0]       key_sync_p1;
  logic [1:0]       sync_fill;
  logic             tick_p0;
  logic             tick_p1;
  logic             tick_p2;
  logic [3:0]       key_deb_p2;
  logic [CNT_W-1:0] deb_cnt [4];
  logic [3:0]       armed;
  logic [3:0]       press_vld_p2;
  logic             pop_vld_p2;

  logic [3:0]       entries [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       count;
  logic [3:0]       direction;
  logic             overflow;

  logic [3:0]       ref_dir;
  logic             reject;
  logic             push_req;
  logic             push_go;
  logic             pop_go;
  logic             drop;

  // Stage p0/p1: two-flop synchronizers; sync_fill marks when p1 holds a real sample
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_sync_p0 <= '1;
      key_sync_p1 <= '1;
      sync_fill   <= '0;
      tick_p0     <= 1'b0;
      tick_p1     <= 1'b0;
      tick_p2     <= 1'b0;
    end else begin
      key_sync_p0 <= q_if.key_i;
      key_sync_p1 <= key_sync_p0;
      sync_fill   <= {sync_fill[0], 1'b1};
      tick_p0     <= q_if.tick_i;
      tick_p1     <= tick_p0;
      tick_p2     <= tick_p1;
    end
  end

  // Stage p2: per-key debounce; a key is armed only once it has been seen released since reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_deb_p2 <= '1;
      armed      <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_sync_p1[i] != key_deb_p2[i]) begin
          if (deb_cnt[i] == CNT_LAST) begin
            key_deb_p2[i] <= key_sync_p1[i];
            deb_cnt[i]    <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
        if (sync_fill[1] && key_sync_p1[i]) armed[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    press_vld_p2 = '0;
    for (int i = 0; i < 4; i++) begin
      press_vld_p2[i] = armed[i] & key_deb_p2[i] & ~key_sync_p1[i] & (deb_cnt[i] == CNT_LAST);
    end
  end

  assign pop_vld_p2 = tick_p1 & ~tick_p2;

  // Queue decision: the reference is the newest pending turn, else the applied direction
  always_comb begin
    ref_dir = (count != 3'd0) ? entries[prev_ptr(wr_ptr)] : direction;
`ifdef DIR_QUEUE_REVERSE_BLOCK_EN
    reject  = (press_vld_p2 == ref_dir) || (press_vld_p2 == opposite_dir(ref_dir));
`else
    reject  = (press_vld_p2 == ref_dir);
`endif
    push_req = q_if.playing_i & $onehot(press_vld_p2) & ~reject;
    pop_go   = q_if.playing_i & pop_vld_p2 & (count != 3'd0);
    push_go  = push_req & ((count != DEPTH_C) | pop_go);
    drop     = push_req & (count == DEPTH_C) & ~pop_go;
  end

  always_ff @(posedge clk_i) begin
    if (push_go) entries[wr_ptr] <= press_vld_p2;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !q_if.playing_i) begin
      direction <= DIR_RIGHT;
      count     <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= drop;
      if (push_go) wr_ptr <= next_ptr(wr_ptr);
      if (pop_go) begin
        direction <= entries[rd_ptr];
        rd_ptr    <= next_ptr(rd_ptr);
      end
      case ({push_go, pop_go})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign q_if.direction_o = direction;
  assign q_if.count_o     = count;
  assign q_if.overflow_o  = overflow;

endmodule

// File: tb/tb_dir_input_queue.sv
// Bench for dir_input_queue: directed scenarios plus random key/tick traffic, every cycle
// checked against a queue-based reference model of the key/tick/queue rules.
module tb_dir_input_queue;
  localparam int DEB   = 4;
  localparam int DEPTH = 2;
`ifdef DIR_QUEUE_REVERSE_BLOCK_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  dir_input_queue_if q_if();

  dir_input_queue #(.DEBOUNCE_CYCLES(DEB), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .q_if    (q_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] kh1, kh2;
  bit         kv1, kv2;
  logic       th1, th2, th3;
  logic [3:0] m_lvl;
  int         m_run [4];
  logic [3:0] m_armed;
  logic [3:0] mq [$];
  logic [3:0] m_dir;
  logic       m_ovf;

  function automatic logic [3:0] opp_of(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] sync_lvl, ev, refd;
    bit         sv, pop, do_pop, acc;
    if (reset) begin
      kh1 = '1; kh2 = '1; kv1 = 0; kv2 = 0;
      th1 = 0; th2 = 0; th3 = 0;
      m_lvl = '1; m_armed = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      mq.delete(); m_dir = 4'b1000; m_ovf = 0;
    end else begin
      sync_lvl = kh2; sv = kv2; ev = '0;
      pop = th2 && !th3;
      for (int i = 0; i < 4; i++) begin
        if (sync_lvl[i] !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = sync_lvl[i];
            m_run[i] = 0;
            if (!sync_lvl[i] && m_armed[i]) ev[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        if (sv && sync_lvl[i]) m_armed[i] = 1'b1;
      end
      if (!q_if.playing_i) begin
        mq.delete(); m_dir = 4'b1000; m_ovf = 0;
      end else begin
        refd   = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
        do_pop = pop && (mq.size() > 0);
        acc    = ($countones(ev) == 1) && (ev != refd) && !(REV && ev == opp_of(refd));
        m_ovf  = acc && (mq.size() == DEPTH) && !do_pop;
        if (do_pop) m_dir = mq.pop_front();
        if (acc && !m_ovf) mq.push_back(ev);
      end
      kh2 = kh1; kv2 = kv1; kh1 = q_if.key_i; kv1 = 1;
      th3 = th2; th2 = th1; th1 = q_if.tick_i;
    end
  end

  task automatic chk_cycle();
    logic [2:0] m_cnt;
    @(negedge clk);
    m_cnt = 3'(mq.size());
    vectors++;
    assert ({q_if.direction_o, q_if.count_o, q_if.overflow_o} === {m_dir, m_cnt, m_ovf}) else begin
      miscompares++;
      $error("FAIL model dir/count/ovf: observed %b/%0d/%b expected %b/%0d/%b",
             q_if.direction_o, q_if.count_o, q_if.overflow_o, m_dir, m_cnt, m_ovf);
    end
    vectors++;
    assert ($onehot(q_if.direction_o) === 1'b1) else begin
      miscompares++;
      $error("FAIL onehot: observed %b expected one-hot", q_if.direction_o);
    end
  endtask

  task automatic run(input int n);
    repeat (n) chk_cycle();
  endtask

  task automatic expect_val(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int idx, output int ovf_seen);
    ovf_seen = 0;
    q_if.key_i[idx] = 1'b0;
    repeat (8) begin chk_cycle(); ovf_seen += int'(q_if.overflow_o); end
    q_if.key_i = '1;
    repeat (8) begin chk_cycle(); ovf_seen += int'(q_if.overflow_o); end
  endtask

  task automatic tick_pulse();
    q_if.tick_i = 1'b1; run(4);
    q_if.tick_i = 1'b0; run(4);
  endtask

  task automatic flush();
    q_if.playing_i = 1'b0; run(1);
    q_if.playing_i = 1'b1; run(1);
  endtask

  initial begin
    int ov;
    reset = 1'b1;
    q_if.key_i = '1; q_if.tick_i = 1'b0; q_if.playing_i = 1'b1;
    run(2);
    expect_val("reset_dir", q_if.direction_o, 8);
    expect_val("reset_count", q_if.count_o, 0);
    expect_val("reset_ovf", q_if.overflow_o, 0);
    reset = 1'b0;
    run(10);

    // Ticks with empty queue leave direction alone
    repeat (3) tick_pulse();
    expect_val("idle_tick_dir", q_if.direction_o, 8);
    expect_val("idle_tick_count", q_if.count_o, 0);

    // Short bounce, then a real press with exact latency
    q_if.key_i[0] = 1'b0; run(3);
    q_if.key_i = '1; run(12);
    expect_val("bounce_count", q_if.count_o, 0);
    q_if.key_i[0] = 1'b0; run(5);
    expect_val("press_cycle5_count", q_if.count_o, 0);
    run(1);
    expect_val("press_cycle6_count", q_if.count_o, 1);
    run(4);
    q_if.key_i = '1; run(8);
    q_if.tick_i = 1'b1; run(2);
    expect_val("pop_cycle2_dir", q_if.direction_o, 8);
    run(1);
    expect_val("pop_cycle3_dir", q_if.direction_o, 1);
    expect_val("pop_cycle3_count", q_if.count_o, 0);
    q_if.tick_i = 1'b0; run(4);

    // Fill to depth and overflow on the third press
    flush();
    press(0, ov); press(2, ov);
    press(1, ov);
    expect_val("overflow_pulses", ov, 1);
    expect_val("full_count", q_if.count_o, 2);
    tick_pulse();
    expect_val("drain1_dir", q_if.direction_o, 1);
    tick_pulse();
    expect_val("drain2_dir", q_if.direction_o, 4);

    // Press event on the same cycle as a pop
    press(0, ov);
    expect_val("pre_coincide_count", q_if.count_o, 1);
    q_if.key_i[2] = 1'b0; run(3);
    q_if.tick_i = 1'b1; run(3);
    expect_val("coincide_count", q_if.count_o, 1);
    expect_val("coincide_dir", q_if.direction_o, 1);
    run(5);
    q_if.key_i = '1; q_if.tick_i = 1'b0; run(8);
    tick_pulse();
    expect_val("coincide_next_dir", q_if.direction_o, 4);

    // Opposite-direction press from right
    flush();
    press(2, ov);
    expect_val("opposite_count", q_if.count_o, REV ? 0 : 1);
    tick_pulse();
    expect_val("opposite_dir", q_if.direction_o, REV ? 8 : 4);

    // Flush via playing_i, then simultaneous two-key press
    flush();
    press(0, ov); press(2, ov);
    expect_val("prefill_count", q_if.count_o, 2);
    q_if.playing_i = 1'b0; run(1);
    expect_val("flush_count", q_if.count_o, 0);
    expect_val("flush_dir", q_if.direction_o, 8);
    q_if.playing_i = 1'b1; run(1);
    q_if.key_i[0] = 1'b0; q_if.key_i[1] = 1'b0; run(8);
    q_if.key_i = '1; run(8);
    expect_val("dual_press_count", q_if.count_o, 0);

    // Reset in the middle of a debounce: held key must not register
    q_if.key_i[0] = 1'b0; run(6);
    reset = 1'b1; run(1);
    reset = 1'b0; run(12);
    expect_val("held_through_reset_count", q_if.count_o, 0);
    q_if.key_i = '1; run(8);
    press(0, ov);
    expect_val("fresh_press_count", q_if.count_o, 1);

    // Random traffic
    repeat (300) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) q_if.key_i = '1;
      else if (r < 90) begin q_if.key_i = '1; q_if.key_i[$urandom_range(0, 3)] = 1'b0; end
      else q_if.key_i = 4'($urandom);
      q_if.tick_i = 1'($urandom);
      q_if.playing_i = ($urandom_range(0, 99) >= 5);
      reset = ($urandom_range(0, 99) == 0);
      run(1);
      reset = 1'b0;
      run($urandom_range(1, 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
